// File: rtl/thumb_pkg.sv
// Shared Thumb definitions: halfword type, 32-bit encoding prefixes and the
// width classifier used by both the fetch aligner and the decoder.
package thumb_pkg;

   typedef logic [15:0] halfword_t;

   localparam logic [4:0] THUMB32_PREFIX_0 = 5'b11101;
   localparam logic [4:0] THUMB32_PREFIX_1 = 5'b11110;
   localparam logic [4:0] THUMB32_PREFIX_2 = 5'b11111;

   localparam halfword_t HW_ZERO = 16'h0000;

   // Only the top five bits matter; the mask keeps the whole halfword in use.
   function automatic logic is_thumb32(input halfword_t hw);
      halfword_t masked;
      masked = hw & 16'hF800;
      return (masked == {THUMB32_PREFIX_0, 11'h000}) ||
             (masked == {THUMB32_PREFIX_1, 11'h000}) ||
             (masked == {THUMB32_PREFIX_2, 11'h000});
   endfunction

endpackage

// File: rtl/thumb_hw_fifo.sv
// Halfword circular buffer: up to two pushes and two pops per cycle, with the
// head entry and the one behind it visible combinationally.
module thumb_hw_fifo
   import thumb_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic [1:0]             push_cnt,
   input  halfword_t              push_hw0,
   input  halfword_t              push_hw1,
   input  logic [1:0]             pop_cnt,
   output logic [$clog2(DEPTH):0] count,
   output halfword_t              hw0,
   output halfword_t              hw1
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]       wr_ptr_reg;
   logic [PTR_W-1:0]       wr_ptr_next;
   logic [PTR_W-1:0]       rd_ptr_reg;
   logic [PTR_W-1:0]       rd_ptr_next;
   logic [CNT_W-1:0]       count_reg;
   logic [CNT_W-1:0]       count_next;
   logic [PTR_W-1:0]       wr_ptr_p1;
   logic [PTR_W-1:0]       rd_ptr_p1;
   logic [DEPTH-1:0][15:0] entries;

   assign wr_ptr_p1 = wr_ptr_reg + PTR_W'(1);
   assign rd_ptr_p1 = rd_ptr_reg + PTR_W'(1);

   // Each entry owns its write enable; a two-halfword push lands in wr_ptr and wr_ptr+1.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         halfword_t entry_reg;
         logic      wr_lo;
         logic      wr_hi;

         assign wr_lo = (push_cnt != 2'd0) && (wr_ptr_reg == PTR_W'(gi));
         assign wr_hi = (push_cnt == 2'd2) && (wr_ptr_p1 == PTR_W'(gi));

         always_ff @(posedge clk) begin
            if (!clr) begin
               if (wr_lo) begin
                  entry_reg <= push_hw0;
               end else if (wr_hi) begin
                  entry_reg <= push_hw1;
               end
            end
         end

         assign entries[gi] = entry_reg;
      end
   endgenerate

   always_comb begin
      wr_ptr_next = wr_ptr_reg + PTR_W'(push_cnt);
      rd_ptr_next = rd_ptr_reg + PTR_W'(pop_cnt);
      count_next  = count_reg + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
      if (clr) begin
         wr_ptr_next = '0;
         rd_ptr_next = '0;
         count_next  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   assign count = count_reg;
   assign hw0   = entries[rd_ptr_reg];
   assign hw1   = entries[rd_ptr_p1];

endmodule

// File: rtl/thumb_fetch_aligner.sv
// Thumb fetch front end: pulls 32-bit words, buffers halfwords and presents
// one 16- or 32-bit instruction per handshake, with flush and halfword restart.
module thumb_fetch_aligner
   import thumb_pkg::*;
#(
   parameter int          BUF_DEPTH = 8,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        fetch_req,
   output logic [31:0] fetch_addr,
   input  logic        fetch_ack,
   input  logic [31:0] fetch_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_is32
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   // At most BUF_DEPTH-2 entries before a request, so a full-word push always fits.
   localparam logic [CNT_W-1:0] REQ_LIMIT = CNT_W'(BUF_DEPTH - 2);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

   localparam logic [0:0] ST_RESET = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   localparam logic [31:0] RESET_FETCH_ADDR = {RESET_PC[31:2], 2'b00};
   localparam logic [31:0] RESET_INST_PC    = {RESET_PC[31:1], 1'b0};

   logic [0:0]       state_reg;
   logic [0:0]       state_next;
   logic [31:0]      fetch_addr_reg;
   logic [31:0]      fetch_addr_next;
   logic             skip_low_reg;
   logic             skip_low_next;
   logic [31:0]      inst_pc_reg;
   logic [31:0]      inst_pc_next;

   logic [CNT_W-1:0] buf_count;
   halfword_t        head_hw0;
   halfword_t        head_hw1;
   logic             head_is32;
   logic             head_valid;
   logic             pop_fire;
   logic [1:0]       pop_cnt;
   logic             req_int;
   logic             ack_fire;
   logic [1:0]       push_cnt;
   halfword_t        push_hw0;
   halfword_t        push_hw1;
   logic             unused_pc_bit;

   assign unused_pc_bit = flush_pc[0];

   thumb_hw_fifo #(
      .DEPTH (BUF_DEPTH)
   ) u_hw_fifo (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .push_cnt (push_cnt),
      .push_hw0 (push_hw0),
      .push_hw1 (push_hw1),
      .pop_cnt  (pop_cnt),
      .count    (buf_count),
      .hw0      (head_hw0),
      .hw1      (head_hw1)
   );

   // A 32-bit head with only one halfword buffered waits for the next word.
   assign head_is32  = (buf_count != '0) && is_thumb32(head_hw0);
   assign head_valid = !flush &&
                       (((buf_count >= CNT_ONE) && !head_is32) || (buf_count >= CNT_TWO));
   assign pop_fire   = head_valid && inst_ready;
   assign pop_cnt    = pop_fire ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;

   assign req_int  = (state_reg == ST_RUN) && (buf_count <= REQ_LIMIT) && !flush;
   assign ack_fire = req_int && fetch_ack;

   // After a restart to an odd halfword, the low half of the first word is dropped.
   assign push_cnt = ack_fire ? (skip_low_reg ? 2'd1 : 2'd2) : 2'd0;
   assign push_hw0 = skip_low_reg ? fetch_rdata[31:16] : fetch_rdata[15:0];
   assign push_hw1 = fetch_rdata[31:16];

   always_comb begin
      state_next      = ST_RUN;
      fetch_addr_next = fetch_addr_reg;
      skip_low_next   = skip_low_reg;
      inst_pc_next    = inst_pc_reg;
      if (flush) begin
         fetch_addr_next = {flush_pc[31:2], 2'b00};
         skip_low_next   = flush_pc[1];
         inst_pc_next    = {flush_pc[31:1], 1'b0};
      end else begin
         if (ack_fire) begin
            fetch_addr_next = fetch_addr_reg + 32'd4;
            skip_low_next   = 1'b0;
         end
         if (pop_fire) begin
            inst_pc_next = inst_pc_reg + (head_is32 ? 32'd4 : 32'd2);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_RESET;
         fetch_addr_reg <= RESET_FETCH_ADDR;
         skip_low_reg   <= RESET_PC[1];
         inst_pc_reg    <= RESET_INST_PC;
      end else begin
         state_reg      <= state_next;
         fetch_addr_reg <= fetch_addr_next;
         skip_low_reg   <= skip_low_next;
         inst_pc_reg    <= inst_pc_next;
      end
   end

   assign fetch_req  = req_int;
   assign fetch_addr = fetch_addr_reg;
   assign inst_valid = head_valid;
   assign inst       = head_valid ? {head_hw0, (head_is32 ? head_hw1 : HW_ZERO)} : 32'h0;
   assign inst_pc    = inst_pc_reg;
   assign inst_is32  = head_is32;

endmodule

// File: tb/tb_thumb_fetch_aligner.sv
// Directed bench for thumb_fetch_aligner: a halfword-queue model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_thumb_fetch_aligner;

   localparam int          BUF_DEPTH = 8;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = 32'h0;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ack = 1'b0;
   logic [31:0] fetch_rdata = 32'h0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_is32;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   thumb_fetch_aligner #(
      .BUF_DEPTH (BUF_DEPTH),
      .RESET_PC  (RESET_PC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ack   (fetch_ack),
      .fetch_rdata (fetch_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst        (inst),
      .inst_pc     (inst_pc),
      .inst_is32   (inst_is32)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   // ---------------- behavioural model: a plain queue of halfwords ----------------
   logic [15:0] m_q[$];
   logic        m_init = 1'b0;
   logic        m_run = 1'b0;
   logic        m_skip = 1'b0;
   logic [31:0] m_fetch_addr = 32'h0;
   logic [31:0] m_pc = 32'h0;

   function automatic logic m_head_is32();
      logic [15:0] h;
      if (m_q.size() == 0) return 1'b0;
      h = m_q[0];
      return h[15:11] >= 5'd29;
   endfunction

   function automatic logic m_valid();
      if (flush) return 1'b0;
      if (m_q.size() >= 2) return 1'b1;
      return (m_q.size() == 1) && !m_head_is32();
   endfunction

   function automatic logic m_req();
      return m_run && !flush && (m_q.size() <= BUF_DEPTH - 2);
   endfunction

   function automatic logic [31:0] m_inst();
      if (!m_valid()) return 32'h0;
      if (m_head_is32()) return {m_q[0], m_q[1]};
      return {m_q[0], 16'h0000};
   endfunction

   initial begin
      logic v, i32, rq;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_q.delete();
            m_run = 1'b0;
            m_skip = RESET_PC[1];
            m_fetch_addr = {RESET_PC[31:2], 2'b00};
            m_pc = {RESET_PC[31:1], 1'b0};
            m_init = 1'b1;
         end else if (m_init) begin
            v = m_valid();
            i32 = m_head_is32();
            rq = m_req();
            if (flush) begin
               m_q.delete();
               m_skip = flush_pc[1];
               m_fetch_addr = {flush_pc[31:2], 2'b00};
               m_pc = {flush_pc[31:1], 1'b0};
            end else begin
               if (v && inst_ready) begin
                  void'(m_q.pop_front());
                  if (i32) void'(m_q.pop_front());
                  m_pc = m_pc + (i32 ? 32'd4 : 32'd2);
               end
               if (rq && fetch_ack) begin
                  if (!m_skip) m_q.push_back(fetch_rdata[15:0]);
                  m_q.push_back(fetch_rdata[31:16]);
                  m_skip = 1'b0;
                  m_fetch_addr = m_fetch_addr + 32'd4;
               end
            end
            m_run = 1'b1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      logic ev;
      forever begin
         @(negedge clk);
         if (m_init) begin
            ev = m_valid();
            chk1("cyc_fetch_req", fetch_req, m_req());
            chk("cyc_fetch_addr", fetch_addr, m_fetch_addr);
            chk1("cyc_inst_valid", inst_valid, ev);
            chk("cyc_inst", inst, m_inst());
            chk("cyc_inst_pc", inst_pc, m_pc);
            if (ev) chk1("cyc_inst_is32", inst_is32, m_head_is32());
         end
      end
   end

   // ---------------- directed stimulus ----------------
   function automatic logic [15:0] hw_at(input logic [31:0] a);
      return {4'h2, a[12:1]};
   endfunction

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {hw_at(a + 32'd2), hw_at(a)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_inst(input string name, input logic [31:0] e_inst,
                              input logic [31:0] e_pc, input logic e_is32);
      @(negedge clk);
      chk1({name, "_valid"}, inst_valid, 1'b1);
      chk({name, "_inst"}, inst, e_inst);
      chk({name, "_pc"}, inst_pc, e_pc);
      chk1({name, "_is32"}, inst_is32, e_is32);
   endtask

   task automatic wait_req(input string name);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (fetch_req) seen = 1'b1;
         step();
      end
      chk1(name, seen, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      rst = 1'b1;
      step();
      step();
      @(negedge clk);
      chk1("rst_fetch_req", fetch_req, 1'b0);
      chk1("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_inst", inst, 32'h0);
      chk1("rst_inst_is32", inst_is32, 1'b0);
      chk("rst_fetch_addr", fetch_addr, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      step();
      rst = 1'b0;
      step();

      // Two 16-bit instructions from one word
      wait_req("t1_req_rises");
      chk("t1_fetch_addr", fetch_addr, 32'h0);
      fetch_ack = 1'b1;
      fetch_rdata = 32'h4148_1C48;
      step();
      fetch_ack = 1'b0;
      expect_inst("t1_a", 32'h1C48_0000, 32'h0, 1'b0);
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      expect_inst("t1_b", 32'h4148_0000, 32'h2, 1'b0);
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      @(negedge clk);
      chk1("t1_empty", inst_valid, 1'b0);
      step();

      // 32-bit instruction straddling two words
      flush = 1'b1;
      flush_pc = 32'h0;
      step();
      flush = 1'b0;
      chk("t2_fetch_addr", fetch_addr, 32'h0);
      fetch_ack = 1'b1;
      fetch_rdata = 32'hF141_2000;
      step();
      fetch_ack = 1'b0;
      expect_inst("t2_a", 32'h2000_0000, 32'h0, 1'b0);
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      @(negedge clk);
      chk1("t2_wait_hw1", inst_valid, 1'b0);
      step();
      fetch_ack = 1'b1;
      fetch_rdata = 32'hABCD_0305;
      step();
      fetch_ack = 1'b0;
      expect_inst("t2_b", 32'hF141_0305, 32'h2, 1'b1);
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      expect_inst("t2_c", 32'hABCD_0000, 32'h6, 1'b0);
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;

      // Backpressure from an odd halfword start: fills to 7 and stops requesting
      flush = 1'b1;
      flush_pc = 32'h0000_0202;
      step();
      flush = 1'b0;
      for (int k = 0; k < 6; k++) begin
         fetch_ack = 1'b1;
         fetch_rdata = word_at(fetch_addr);
         step();
      end
      fetch_ack = 1'b0;
      @(negedge clk);
      chk1("t3_req_drop", fetch_req, 1'b0);
      chk("t3_fetch_addr", fetch_addr, 32'h0000_0210);
      step();
      inst_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         expect_inst($sformatf("t3_drain%0d", i),
                     {hw_at(32'h202 + 32'(2 * i)), 16'h0000},
                     32'h202 + 32'(2 * i), 1'b0);
         step();
      end
      @(negedge clk);
      chk1("t3_no_dup", inst_valid, 1'b0);
      step();
      inst_ready = 1'b0;

      // Misaligned flush target
      flush = 1'b1;
      flush_pc = 32'h0000_1002;
      step();
      flush = 1'b0;
      chk("t4_fetch_addr", fetch_addr, 32'h0000_1000);
      fetch_ack = 1'b1;
      fetch_rdata = 32'hBF00_1234;
      step();
      fetch_ack = 1'b0;
      expect_inst("t4", 32'hBF00_0000, 32'h0000_1002, 1'b0);
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      @(negedge clk);
      chk1("t4_only_one", inst_valid, 1'b0);
      step();

      // Flush coincident with ack and handshake
      flush = 1'b1;
      flush_pc = 32'h0000_2000;
      step();
      flush = 1'b0;
      fetch_ack = 1'b1;
      fetch_rdata = 32'h3333_2222;
      step();
      fetch_ack = 1'b0;
      expect_inst("t5_pre", 32'h2222_0000, 32'h0000_2000, 1'b0);
      step();
      flush = 1'b1;
      flush_pc = 32'h0000_3004;
      fetch_ack = 1'b1;
      fetch_rdata = 32'h4444_5555;
      inst_ready = 1'b1;
      @(negedge clk);
      chk1("t5_valid_in_flush", inst_valid, 1'b0);
      chk1("t5_req_in_flush", fetch_req, 1'b0);
      step();
      flush = 1'b0;
      fetch_ack = 1'b0;
      inst_ready = 1'b0;
      @(negedge clk);
      chk1("t5_dropped", inst_valid, 1'b0);
      chk("t5_inst_pc", inst_pc, 32'h0000_3004);
      chk("t5_fetch_addr", fetch_addr, 32'h0000_3004);
      step();
      fetch_ack = 1'b1;
      fetch_rdata = 32'h6666_7777;
      step();
      fetch_ack = 1'b0;
      expect_inst("t5_post", 32'h7777_0000, 32'h0000_3004, 1'b0);
      step();

      // Address wrap, pc wrap, then reset with a full buffer
      flush = 1'b1;
      flush_pc = 32'hFFFF_FFFC;
      step();
      flush = 1'b0;
      fetch_ack = 1'b1;
      fetch_rdata = 32'h1111_0001;
      step();
      fetch_ack = 1'b0;
      expect_inst("t6_top", 32'h0001_0000, 32'hFFFF_FFFC, 1'b0);
      chk("t6_addr_wrap", fetch_addr, 32'h0);
      step();
      for (int k = 0; k < 3; k++) begin
         fetch_ack = 1'b1;
         fetch_rdata = word_at(fetch_addr);
         step();
      end
      fetch_ack = 1'b0;
      @(negedge clk);
      chk1("t6_full_req", fetch_req, 1'b0);
      step();
      inst_ready = 1'b1;
      step();
      step();
      inst_ready = 1'b0;
      expect_inst("t6_pc_wrap", 32'h2000_0000, 32'h0, 1'b0);
      step();
      fetch_ack = 1'b1;
      fetch_rdata = word_at(fetch_addr);
      step();
      fetch_ack = 1'b0;
      rst = 1'b1;
      fetch_ack = 1'b1;
      inst_ready = 1'b1;
      step();
      @(negedge clk);
      chk1("t6_rst_valid", inst_valid, 1'b0);
      chk1("t6_rst_req", fetch_req, 1'b0);
      chk("t6_rst_addr", fetch_addr, {RESET_PC[31:2], 2'b00});
      chk("t6_rst_pc", inst_pc, 32'h0);
      chk("t6_rst_inst", inst, 32'h0);
      step();
      rst = 1'b0;
      fetch_ack = 1'b0;
      inst_ready = 1'b0;
      step();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
